serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. One full adder processes the operands
// LSB-first, one bit per clock, and the result shifts into sum from the MSB
// side. A start accepted in IDLE is followed by WIDTH cycles in RUN and one
// cycle in DONE, during which done pulses.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' port. With
// sub=1 the block computes a-b-cin as a+~b+~cin, and cout is the borrow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic             bit_s;
  logic             carry_s;
  logic [WIDTH:0]   sum_ext_s;

  // Single full adder on the current LSBs; the new result bit enters from the MSB side.
  always_comb begin
    bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    carry_s   = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    sum_ext_s = {bit_s, sum_q};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtract runs as a + ~b + ~cin; the final carry is inverted into a borrow.
          sub_d   = sub;
          b_sh_d  = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
`else
          b_sh_d  = b;
          c_d     = cin;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1'b1;
        b_sh_d = b_sh_q >> 1'b1;
        c_d    = carry_s;
        sum_d  = sum_ext_s[WIDTH:1];
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
          cout_d  = carry_s ^ sub_q;
`else
          cout_d  = carry_s;
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
